// File: rtl/wr_sel_if.sv
// -----------------------------------------------------------------------------
// wr_sel_if
// Groups the request and select signals of wr_sel_decoder.
//
// Parameters:
//   ADDR_W    select address width. OUT_W = 2**ADDR_W select lines.
//
// Signals:
//   en        decode request, sampled each cycle       (master -> slave)
//   addr      entry index, bit 0 = LSB                  (master -> slave)
//   clr_start start a clear sweep, level-sampled        (master -> slave)
//   out       registered one-hot select, out[k]=entry k (slave -> master)
//   busy      high while a sweep is in progress         (slave -> master)
//   done      one-cycle pulse at sweep completion       (slave -> master)
//   dropped   one-cycle pulse when an en is discarded   (slave -> master)
//
// Handshake: there is no back-pressure. en is a fire-and-forget request
// that is either decoded on the next edge or discarded, in which case
// dropped pulses one cycle later. Requests are never queued.
// -----------------------------------------------------------------------------
interface wr_sel_if #(
  parameter int ADDR_W = 3
);
  localparam int OUT_W = 2 ** ADDR_W;

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              clr_start;
  logic [OUT_W-1:0]  out;
  logic              busy;
  logic              done;
  logic              dropped;

  modport master (
    output en, addr, clr_start,
    input  out, busy, done, dropped
  );

  modport slave (
    input  en, addr, clr_start,
    output out, busy, done, dropped
  );
endinterface

// File: rtl/wr_sel_decoder.sv
// -----------------------------------------------------------------------------
// wr_sel_decoder
// Registered N-to-2^N one-hot decoder that produces the per-entry write
// selects of the register file. It includes a clear-sweep sequencer that
// walks every entry one-hot in ascending order, HOLD cycles per entry, so
// the register file can be zeroed without datapath involvement.
//
// Parameters:
//   ADDR_W  select address width (OUT_W = 2**ADDR_W outputs)
//   HOLD    cycles each entry stays selected during a sweep, 1..255
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        wr_sel_if slave modport (en, addr, clr_start in;
//              out, busy, done, dropped out -- all outputs registered)
//   state_dbg  1 while the FSM is in SWEEP, 0 in IDLE
//
// Optional feature:
//   WR_SEL_ZERO_REG_PROTECT_EN  when defined, out[OUT_W-1] is forced to 0
//   in all modes (hardwired zero register). An en request for that entry is
//   dropped; a sweep still spends HOLD cycles on it with out=0.
// -----------------------------------------------------------------------------
module wr_sel_decoder #(
  parameter int ADDR_W = 3,
  parameter int HOLD   = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  wr_sel_if.slave   bus,
  output logic      state_dbg
);

  localparam int OUT_W = 2 ** ADDR_W;

  localparam logic [OUT_W-1:0]  ONE       = OUT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dropped_q, dropped_d;

  function automatic logic [OUT_W-1:0] one_hot(input logic [ADDR_W-1:0] a);
    one_hot = ONE << a;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    out_d      = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dropped_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.clr_start) begin
          // clr_start wins over en; a coincident en is discarded.
          state_d    = SWEEP;
          idx_d      = '0;
          hold_cnt_d = '0;
          out_d      = one_hot('0);
          busy_d     = 1'b1;
          dropped_d  = bus.en;
        end else if (bus.en) begin
          out_d = one_hot(bus.addr);
`ifdef WR_SEL_ZERO_REG_PROTECT_EN
          if (bus.addr == IDX_LAST) begin
            dropped_d = 1'b1;
          end
`endif
        end
      end

      SWEEP: begin
        // Any en during a sweep is discarded; clr_start is ignored.
        dropped_d = bus.en;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            // Last slot of the last entry: leave in one edge so that done
            // and busy-low appear together.
            state_d = IDLE;
            idx_d   = '0;
            out_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            out_d = one_hot(idx_q + 1'b1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          out_d      = one_hot(idx_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef WR_SEL_ZERO_REG_PROTECT_EN
    // Entry OUT_W-1 is the hardwired zero register: never select it.
    out_d[OUT_W-1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dropped_q  <= dropped_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.dropped = dropped_q;
  assign state_dbg   = (state_q == SWEEP);

endmodule

// File: tb/tb_wr_sel_decoder.sv
// -----------------------------------------------------------------------------
// tb_wr_sel_decoder
// Drives two decoders (HOLD=1 and HOLD=3) with identical stimulus and checks
// both against a sweep-position reference model every cycle.
// -----------------------------------------------------------------------------
module tb_wr_sel_decoder;
  localparam int ADDR_W = 3;
  localparam int OUT_W  = 8;
  localparam int HOLD_A = 1;
  localparam int HOLD_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              clr_start;
  logic              dbg_a, dbg_b;

  int checks = 0;
  int errors = 0;

  wr_sel_if #(.ADDR_W(ADDR_W)) bus_a ();
  wr_sel_if #(.ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.en        = en;
  assign bus_a.addr      = addr;
  assign bus_a.clr_start = clr_start;
  assign bus_b.en        = en;
  assign bus_b.addr      = addr;
  assign bus_b.clr_start = clr_start;

  wr_sel_decoder #(.ADDR_W(ADDR_W), .HOLD(HOLD_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .state_dbg(dbg_a)
  );
  wr_sel_decoder #(.ADDR_W(ADDR_W), .HOLD(HOLD_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .state_dbg(dbg_b)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos = cycles elapsed since sweep entry (-1 = idle). During a sweep the
  // selected entry is simply pos / HOLD.
  int             pos    [2];
  int             hold_v [2];
  logic [7:0]     m_out  [2];
  logic           m_busy [2];
  logic           m_done [2];
  logic           m_drop [2];
  logic [2*OUT_W+5:0] exp_q[$];  // {drop,done,busy} x2, out_b, out_a

  function automatic logic [7:0] mask(input logic [7:0] v);
`ifdef WR_SEL_ZERO_REG_PROTECT_EN
    return v & 8'h7f;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      pos[m] = -1; m_out[m] = '0; m_busy[m] = 0; m_done[m] = 0; m_drop[m] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_drop[m] = 1'b0;
      m_done[m] = 1'b0;
      if (pos[m] < 0) begin
        if (clr_start) begin
          pos[m] = 0; m_out[m] = mask(8'h01); m_busy[m] = 1'b1; m_drop[m] = en;
        end else begin
          m_busy[m] = 1'b0;
          m_out[m]  = en ? 8'(1 << addr) : 8'h00;
`ifdef WR_SEL_ZERO_REG_PROTECT_EN
          if (en && addr == 3'(OUT_W - 1)) begin
            m_out[m] = 8'h00; m_drop[m] = 1'b1;
          end
`endif
        end
      end else begin
        m_drop[m] = en;
        pos[m]++;
        if (pos[m] == OUT_W * hold_v[m]) begin
          pos[m] = -1; m_out[m] = 8'h00; m_busy[m] = 1'b0; m_done[m] = 1'b1;
        end else begin
          m_out[m] = mask(8'(1 << (pos[m] / hold_v[m]))); m_busy[m] = 1'b1;
        end
      end
    end
    exp_q.push_back({m_drop[1], m_done[1], m_busy[1], m_drop[0], m_done[0], m_busy[0],
                     m_out[1], m_out[0]});
  endtask

  task automatic check_outputs();
    logic [2*OUT_W+5:0] e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("out_a",     32'(bus_a.out),     32'(e[7:0]));
    chk("busy_a",    32'(bus_a.busy),    32'(e[16]));
    chk("done_a",    32'(bus_a.done),    32'(e[17]));
    chk("dropped_a", 32'(bus_a.dropped), 32'(e[18]));
    chk("out_b",     32'(bus_b.out),     32'(e[15:8]));
    chk("busy_b",    32'(bus_b.busy),    32'(e[19]));
    chk("done_b",    32'(bus_b.done),    32'(e[20]));
    chk("dropped_b", 32'(bus_b.dropped), 32'(e[21]));
    chk("onehot_a",  32'($countones(bus_a.out) <= 1), 32'd1);
    chk("onehot_b",  32'($countones(bus_b.out) <= 1), 32'd1);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let the posedge happen, check at next negedge.
  task automatic step(input logic e, input logic [ADDR_W-1:0] a, input logic c);
    en = e; addr = a; clr_start = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_a"},  32'(bus_a.out),  32'd0);
    chk({tag, "_busy_a"}, 32'(bus_a.busy), 32'd0);
    chk({tag, "_done_a"}, 32'(bus_a.done), 32'd0);
    chk({tag, "_drop_a"}, 32'(bus_a.dropped), 32'd0);
    chk({tag, "_out_b"},  32'(bus_b.out),  32'd0);
    chk({tag, "_busy_b"}, 32'(bus_b.busy), 32'd0);
    chk({tag, "_done_b"}, 32'(bus_b.done), 32'd0);
    chk({tag, "_state_b"}, 32'(dbg_b), 32'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    hold_v[0] = HOLD_A;
    hold_v[1] = HOLD_B;
    en = 1'b0; addr = '0; clr_start = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Decode after reset, then en=0 clears.
    step(1'b1, 3'd5, 1'b0);
    chk("decode_addr5", 32'(bus_a.out), 32'h20);
    step(1'b0, 3'd0, 1'b0);

    // Full decode walk on consecutive cycles.
    for (int i = 0; i < OUT_W; i++) step(1'b1, 3'(i), 1'b0);
    step(1'b0, 3'd0, 1'b0);

    // Single-cycle clr_start, plain sweep on both instances.
    step(1'b0, 3'd0, 1'b1);
    repeat (OUT_W * HOLD_B + 2) step(1'b0, 3'd0, 1'b0);

    // Sweep with interference: coincident en, mid-sweep en and clr_start.
    step(1'b1, 3'd2, 1'b1);
    repeat (3) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);
    repeat (6) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd6, 1'b1);
    repeat (OUT_W * HOLD_B) step(1'b0, 3'd0, 1'b0);

    // clr_start held high: back-to-back sweeps.
    repeat (2 * OUT_W * HOLD_B + 6) step(1'b0, 3'd0, 1'b1);
    repeat (OUT_W * HOLD_B + 2) step(1'b0, 3'd0, 1'b0);

    // Reset mid-sweep: HOLD=3 instance is at entry 4.
    step(1'b0, 3'd0, 1'b1);
    repeat (4 * HOLD_B + 1) step(1'b0, 3'd0, 1'b0);
    chk("pre_reset_out_b", 32'(bus_b.out), 32'h10);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    chk("no_done_after_reset", 32'(bus_b.done), 32'd0);
    step(1'b1, 3'd1, 1'b0);
    chk("decode_after_reset", 32'(bus_b.out), 32'h02);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, OUT_W - 1)),
           1'($urandom_range(0, 15) == 0));
    end
    repeat (OUT_W * HOLD_B + 2) step(1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
